// File: rtl/comparator_unit_pkg.sv
// Shared result encoding for the comparator: one-hot {gt,lt,eq}.
package comparator_unit_pkg;
  typedef logic [2:0] cmp_result_t;

  localparam cmp_result_t CMP_EQ = 3'b001;
  localparam cmp_result_t CMP_LT = 3'b010;
  localparam cmp_result_t CMP_GT = 3'b100;
endpackage

// File: rtl/comparator_unit_cmp_core.sv
// Unregistered magnitude/equality compare; signed mode flips the sign bit
// so both modes reduce to one unsigned compare.
module cmp_core
  import comparator_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output cmp_result_t      res
);
  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] xk;
  logic [WIDTH-1:0] yk;

  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = signed_mode;
    xk                   = x ^ sign_flip;
    yk                   = y ^ sign_flip;
    if (xk == yk)      res = CMP_EQ;
    else if (xk < yk)  res = CMP_LT;
    else               res = CMP_GT;
  end
endmodule

// File: rtl/comparator_unit.sv
// Registered comparator: one-cycle latency results plus a saturating
// mismatch counter for datapath health monitoring.
module comparator_unit
  import comparator_unit_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             clr_count,
  output logic             out_valid,
  output logic             z,
  output logic             lt,
  output logic             gt,
  output logic [CNT_W-1:0] mismatch_count
);
  cmp_result_t      res_now, res_d, res_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .x           (x),
    .y           (y),
    .signed_mode (signed_mode),
    .res         (res_now)
  );

  always_comb begin
    valid_d = in_valid;
    res_d   = in_valid ? res_now : res_q;
    cnt_d   = cnt_q;
    // Clear wins over a same-cycle increment.
    if (clr_count)
      cnt_d = '0;
    else if (in_valid && res_now != CMP_EQ && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign z              = res_q[0];
  assign lt             = res_q[1];
  assign gt             = res_q[2];
  assign mismatch_count = cnt_q;
endmodule

// File: tb/tb_comparator_unit.sv
// Directed checks of comparator_unit at WIDTH=1, WIDTH=8 and a 2-bit counter,
// plus a short randomized pass against a behavioural compare.
module tb_comparator_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=1, CNT_W=8
  logic a_iv, a_sm, a_clr, a_ov, a_z, a_lt, a_gt;
  logic [0:0] a_x, a_y;
  logic [7:0] a_cnt;
  // WIDTH=8, CNT_W=8
  logic b_iv, b_sm, b_clr, b_ov, b_z, b_lt, b_gt;
  logic [7:0] b_x, b_y;
  logic [7:0] b_cnt;
  // WIDTH=8, CNT_W=2
  logic c_iv, c_sm, c_clr, c_ov, c_z, c_lt, c_gt;
  logic [7:0] c_x, c_y;
  logic [1:0] c_cnt;

  comparator_unit #(.WIDTH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .signed_mode(a_sm), .x(a_x), .y(a_y),
    .clr_count(a_clr), .out_valid(a_ov), .z(a_z), .lt(a_lt), .gt(a_gt),
    .mismatch_count(a_cnt));

  comparator_unit #(.WIDTH(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .signed_mode(b_sm), .x(b_x), .y(b_y),
    .clr_count(b_clr), .out_valid(b_ov), .z(b_z), .lt(b_lt), .gt(b_gt),
    .mismatch_count(b_cnt));

  comparator_unit #(.WIDTH(8), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .signed_mode(c_sm), .x(c_x), .y(c_y),
    .clr_count(c_clr), .out_valid(c_ov), .z(c_z), .lt(c_lt), .gt(c_gt),
    .mismatch_count(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       xs [7];
    logic       ys [7];
    logic [2:0] exp_r [7];
    int         exp_cnt [7];
    int         model_cnt;
    logic [2:0] exp_rr;

    xs      = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ys      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_r   = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b100};
    exp_cnt = '{0, 1, 1, 2, 2, 3, 3};

    rst = 1'b1;
    a_iv = 0; a_sm = 0; a_clr = 0; a_x = 0; a_y = 0;
    b_iv = 0; b_sm = 0; b_clr = 0; b_x = 0; b_y = 0;
    c_iv = 0; c_sm = 0; c_clr = 0; c_x = 0; c_y = 0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset: everything stays zero
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_a_flags", {a_ov, a_z, a_lt, a_gt}, 4'b0000);
      chk("idle_a_cnt", a_cnt, 0);
      chk("idle_b_flags", {b_ov, b_z, b_lt, b_gt}, 4'b0000);
    end

    // WIDTH=1 unsigned sequence
    for (int i = 0; i < 7; i++) begin
      a_iv = 1; a_sm = 0; a_x = xs[i]; a_y = ys[i];
      tick();
      chk($sformatf("w1_res%0d", i), {a_ov, a_z, a_lt, a_gt}, {1'b1, exp_r[i]});
      chk($sformatf("w1_cnt%0d", i), a_cnt, exp_cnt[i]);
    end
    a_iv = 0; a_x = 1; a_y = 0;
    tick();
    chk("w1_hold", {a_ov, a_z, a_lt, a_gt}, 4'b0100);
    chk("w1_hold_cnt", a_cnt, 3);

    // WIDTH=1 signed: 1 is -1, so -1 < 0
    a_iv = 1; a_sm = 1; a_x = 1; a_y = 0;
    tick();
    chk("w1_signed", {a_ov, a_z, a_lt, a_gt}, 4'b1010);
    chk("w1_signed_cnt", a_cnt, 4);
    a_iv = 0;

    // WIDTH=8 signed vs unsigned
    b_iv = 1; b_sm = 1; b_x = 8'hFF; b_y = 8'h01;
    tick();
    chk("w8_s_ff_01", {b_ov, b_z, b_lt, b_gt}, 4'b1010);
    b_sm = 0;
    tick();
    chk("w8_u_ff_01", {b_ov, b_z, b_lt, b_gt}, 4'b1001);
    b_sm = 1; b_x = 8'h80; b_y = 8'h7F;
    tick();
    chk("w8_s_80_7f", {b_ov, b_z, b_lt, b_gt}, 4'b1010);
    b_sm = 0;
    tick();
    chk("w8_u_80_7f", {b_ov, b_z, b_lt, b_gt}, 4'b1001);
    b_x = 8'h5A; b_y = 8'h5A;
    tick();
    chk("w8_eq", {b_ov, b_z, b_lt, b_gt}, 4'b1100);
    chk("w8_cnt", b_cnt, 4);
    b_iv = 0;

    // CNT_W=2 saturation, then clear beats increment
    c_iv = 1; c_sm = 0; c_x = 8'h10; c_y = 8'h20;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_cnt%0d", i), c_cnt, (i < 3) ? i + 1 : 3);
    end
    c_clr = 1;
    tick();
    chk("clr_vs_inc", c_cnt, 0);
    chk("clr_res", {c_ov, c_z, c_lt, c_gt}, 4'b1010);
    c_clr = 0;
    tick();
    chk("after_clr", c_cnt, 1);

    // Reset with a live mismatching sample: sample discarded
    rst = 1; c_x = 8'h01; c_y = 8'h02;
    tick();
    chk("rst_mid_flags", {c_ov, c_z, c_lt, c_gt}, 4'b0000);
    chk("rst_mid_cnt", c_cnt, 0);
    rst = 0; c_x = 8'h07; c_y = 8'h03;
    tick();
    chk("post_rst_res", {c_ov, c_z, c_lt, c_gt}, 4'b1001);
    chk("post_rst_cnt", c_cnt, 1);
    c_iv = 0;

    // Randomized pass on WIDTH=8 (counter was cleared by the reset above)
    model_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      b_iv = 1;
      b_sm = $urandom_range(0, 1);
      b_x  = $urandom_range(0, 255);
      b_y  = (i % 5 == 0) ? b_x : 8'($urandom_range(0, 255));
      if (b_x == b_y) exp_rr = 3'b100;
      else if (b_sm ? ($signed(b_x) < $signed(b_y)) : (b_x < b_y)) exp_rr = 3'b010;
      else exp_rr = 3'b001;
      if (b_x != b_y && model_cnt < 255) model_cnt++;
      tick();
      chk("rnd_res", {b_ov, b_z, b_lt, b_gt}, {1'b1, exp_rr});
      chk("rnd_onehot", 32'($onehot({b_z, b_lt, b_gt})), 1);
      chk("rnd_cnt", b_cnt, model_cnt);
    end
    b_iv = 0;
    tick();
    chk("rnd_idle_valid", b_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
